// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between an ALU
// writeback requester (A) and a load writeback requester (B) using a
// round-robin valid/ready handshake. The winning write is registered for one
// cycle before it reaches the register file. A clear sequence zeroes x1..x31,
// one register per cycle.
module reg_write_arbiter (
    input  logic        clk_Regs,
    input  logic        rst,
    input  logic        clr_start,
    output logic        clr_busy,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        Reg_Write,
    output logic [4:0]  W_Addr,
    output logic [31:0] W_Data
);

    localparam logic ST_ARB   = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    localparam logic [4:0] LAST_REG = 5'd31;

    logic       state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [4:0] cnt_q, cnt_d;

    logic        wr_en_d;
    logic [4:0]  wr_addr_d;
    logic [31:0] wr_data_d;

    logic grant_a, grant_b;

    // Grant decision: round-robin on contention, nothing while clearing,
    // requesting a clear, or held in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && state_q == ST_ARB && !clr_start) begin
            if (a_valid && b_valid) begin
                if (ptr_q == PTR_A) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign clr_busy = (state_q == ST_CLEAR);

    // Next-state for the FSM, pointer, clear counter and the write register.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        // Address/data hold their previous values unless a real write lands.
        wr_addr_d = W_Addr;
        wr_data_d = W_Data;

        if (state_q == ST_ARB) begin
            if (clr_start) begin
                state_d = ST_CLEAR;
                cnt_d   = 5'd1;
            end else if (grant_a) begin
                ptr_d = PTR_B;
                // x0 is hardwired zero: complete the handshake but drop the write.
                if (a_addr != 5'd0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = a_addr;
                    wr_data_d = a_data;
                end
            end else if (grant_b) begin
                ptr_d = PTR_A;
                if (b_addr != 5'd0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = b_addr;
                    wr_data_d = b_data;
                end
            end
        end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = 32'd0;
            if (cnt_q == LAST_REG) begin
                state_d = ST_ARB;
                cnt_d   = 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // State and registered write-port update; reset aborts any clear in flight.
    always_ff @(posedge clk_Regs) begin
        if (rst) begin
            state_q   <= ST_ARB;
            ptr_q     <= PTR_A;
            cnt_q     <= 5'd0;
            Reg_Write <= 1'b0;
            W_Addr    <= 5'd0;
            W_Data    <= 32'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            Reg_Write <= wr_en_d;
            W_Addr    <= wr_addr_d;
            W_Data    <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_reg_write_arbiter;

    logic        clk_Regs;
    logic        rst;
    logic        clr_start;
    logic        clr_busy;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        Reg_Write;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;

    int total = 0;
    int bad   = 0;

    reg_write_arbiter dut (
        .clk_Regs  (clk_Regs),
        .rst       (rst),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .Reg_Write (Reg_Write),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data)
    );

    initial clk_Regs = 1'b0;
    always #5 clk_Regs = ~clk_Regs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_Regs);
        #1;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr_start = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;
        next_cycle();
        // Reset state: readies forced low even with both requesters valid.
        @(negedge clk_Regs);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_wr", {31'd0, Reg_Write}, 32'd0);
        check("rst_waddr", {27'd0, W_Addr}, 32'd0);
        check("rst_wdata", W_Data, 32'd0);
        check("rst_busy", {31'd0, clr_busy}, 32'd0);
        next_cycle();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        next_cycle();

        // Single A write: ready now, on the port next cycle, gone after.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        @(negedge clk_Regs);
        check("t1_a_ready", {31'd0, a_ready}, 32'd1);
        check("t1_b_ready", {31'd0, b_ready}, 32'd0);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk_Regs);
        check("t1_wr", {31'd0, Reg_Write}, 32'd1);
        check("t1_waddr", {27'd0, W_Addr}, 32'd5);
        check("t1_wdata", W_Data, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk_Regs);
        check("t1_wr_off", {31'd0, Reg_Write}, 32'd0);
        check("t1_waddr_hold", {27'd0, W_Addr}, 32'd5);

        // Re-reset so the pointer is back at A, then contend for 6 cycles.
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA0003;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hBBBB0004;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_Regs);
            check("rr_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_b_ready", {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_one_hot", {31'd0, a_ready & b_ready}, 32'd0);
            if (i > 0) begin
                // Previous cycle's winner is now on the port.
                check("rr_wr", {31'd0, Reg_Write}, 32'd1);
                check("rr_waddr", {27'd0, W_Addr}, (i % 2 == 1) ? 32'd3 : 32'd4);
            end
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk_Regs);
        check("rr_last_waddr", {27'd0, W_Addr}, 32'd4);
        check("rr_last_wdata", W_Data, 32'hBBBB0004);
        next_cycle();

        // B writes x0: handshake completes, port stays idle and holds.
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        @(negedge clk_Regs);
        check("x0_b_ready", {31'd0, b_ready}, 32'd1);
        next_cycle();
        b_valid = 1'b0;
        @(negedge clk_Regs);
        check("x0_wr", {31'd0, Reg_Write}, 32'd0);
        check("x0_waddr", {27'd0, W_Addr}, 32'd4);
        check("x0_wdata", W_Data, 32'hBBBB0004);
        next_cycle();

        // Clear with A pending; second clr_start mid-sequence must be ignored.
        clr_start = 1'b1; a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        @(negedge clk_Regs);
        check("clr_a_ready_T", {31'd0, a_ready}, 32'd0);
        check("clr_busy_T", {31'd0, clr_busy}, 32'd0);
        next_cycle();
        clr_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            clr_start = (k == 5);
            @(negedge clk_Regs);
            check("clr_busy", {31'd0, clr_busy}, 32'd1);
            check("clr_a_ready", {31'd0, a_ready}, 32'd0);
            if (k >= 2) begin
                check("clr_wr", {31'd0, Reg_Write}, 32'd1);
                check("clr_waddr", {27'd0, W_Addr}, k - 1);
                check("clr_wdata", W_Data, 32'd0);
            end
            next_cycle();
        end
        clr_start = 1'b0;
        // T+32: back in ARB, last clear write visible, A granted.
        @(negedge clk_Regs);
        check("clr_end_busy", {31'd0, clr_busy}, 32'd0);
        check("clr_end_wr", {31'd0, Reg_Write}, 32'd1);
        check("clr_end_waddr", {27'd0, W_Addr}, 32'd31);
        check("clr_end_a_ready", {31'd0, a_ready}, 32'd1);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk_Regs);
        check("post_clr_wr", {31'd0, Reg_Write}, 32'd1);
        check("post_clr_waddr", {27'd0, W_Addr}, 32'd7);
        check("post_clr_wdata", W_Data, 32'h77);
        next_cycle();

        // Reset in clear cycle 10 aborts; pointer (currently B) returns to A.
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk_Regs);
        check("abort_busy_in_rst", {31'd0, clr_busy}, 32'd1);
        next_cycle();
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h9;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hA;
        @(negedge clk_Regs);
        check("abort_busy", {31'd0, clr_busy}, 32'd0);
        check("abort_wr", {31'd0, Reg_Write}, 32'd0);
        check("abort_waddr", {27'd0, W_Addr}, 32'd0);
        check("abort_wdata", W_Data, 32'd0);
        check("abort_a_ready", {31'd0, a_ready}, 32'd1);
        check("abort_b_ready", {31'd0, b_ready}, 32'd0);
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk_Regs);
        check("abort_next_wr", {31'd0, Reg_Write}, 32'd1);
        check("abort_next_waddr", {27'd0, W_Addr}, 32'd9);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
